// File: rtl/picosoc_iomem_mux.sv
// picosoc_iomem_mux: decodes the CPU-side iomem bus onto NUM_SLAVES
// peripheral ports using base/mask windows. Slave strobes and request
// fields are registered. A per-transaction timeout aborts requests to slaves
// that never answer. Decode misses and timeouts complete on the master side
// with ERR_RDATA and update a small error status block.
`timescale 1ns/1ps

module picosoc_iomem_mux #(
    parameter int                      NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE    = {NUM_SLAVES{32'h0300_0000}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK    = {NUM_SLAVES{32'hFF00_0000}},
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERR_RDATA      = 32'hBADD_ADD5
) (
    input  logic                       clk,
    input  logic                       reset,
    // master side
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [3:0]                 m_wstrb,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    output logic [31:0]                m_rdata,
    // slave side
    output logic [NUM_SLAVES-1:0]      s_valid,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    output logic [3:0]                 s_wstrb,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    // error status
    output logic                       err_irq,
    output logic [7:0]                 err_count,
    output logic [31:0]                err_addr,
    output logic                       err_timeout
);

    localparam int          IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        RESP,
        DERR,
        TOUT
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       sel;
    logic [15:0]            tout_cnt;

    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;
    logic [7:0]             err_count_next;

    // Address decode: scan from the top index down so the lowest matching window wins.
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips the assignment would infer a latch.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[32*i +: 32]) ==
                (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Route the ready and read data of the currently selected slave only.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == IDX_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    // Saturating increment shared by both error paths.
    always_comb begin
        err_count_next = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    end

    // Transaction FSM; every output is registered so slave strobes cannot glitch.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen at the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= '0;
            tout_cnt    <= '0;
            m_ready     <= 1'b0;
            m_rdata     <= '0;
            s_valid     <= '0;
            s_wstrb     <= '0;
            s_addr      <= '0;
            s_wdata     <= '0;
            err_irq     <= 1'b0;
            err_count   <= '0;
            err_addr    <= '0;
            err_timeout <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            err_irq <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        s_addr   <= m_addr;
                        s_wdata  <= m_wdata;
                        s_wstrb  <= m_wstrb;
                        tout_cnt <= '0;
                        if (hit) begin
                            sel     <= hit_idx;
                            s_valid <= NUM_SLAVES'(1) << hit_idx;
                            state   <= BUSY;
                        end else begin
                            m_ready     <= 1'b1;
                            m_rdata     <= ERR_RDATA;
                            err_irq     <= 1'b1;
                            err_count   <= err_count_next;
                            err_addr    <= m_addr;
                            err_timeout <= 1'b0;
                            state       <= DERR;
                        end
                    end
                end
                BUSY: begin
                    if (!m_valid) begin
                        // master withdrew the request: silent abort
                        s_valid <= '0;
                        state   <= IDLE;
                    end else if (sel_ready) begin
                        m_rdata <= sel_rdata;
                        m_ready <= 1'b1;
                        s_valid <= '0;
                        state   <= RESP;
                    end else if (tout_cnt == TOUT_LAST) begin
                        s_valid     <= '0;
                        m_ready     <= 1'b1;
                        m_rdata     <= ERR_RDATA;
                        err_irq     <= 1'b1;
                        err_count   <= err_count_next;
                        err_addr    <= s_addr;
                        err_timeout <= 1'b1;
                        state       <= TOUT;
                    end else begin
                        tout_cnt <= tout_cnt + 16'd1;
                    end
                end
                RESP, DERR, TOUT: begin
                    // m_ready and error status were loaded on entry; this is the response cycle
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_iomem_mux.sv
// Self-checking bench for picosoc_iomem_mux. Slaves are modelled by a wait
// count per port. The reference model decides each transaction's outcome
// from the window table and latency rules, and one negedge process compares
// every output against it on every cycle.
`timescale 1ns/1ps

module tb_picosoc_iomem_mux;

    localparam int          NS  = 4;
    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hBADD_ADD5;

    // window table: slave 3 overlaps 0x02xx_xxxx and 0x03xx_xxxx, lower indices win
    localparam logic [31:0] BASE_TAB [NS] = '{32'h0200_0000, 32'h0310_0000, 32'h0320_0000, 32'h0200_0000};
    localparam logic [31:0] MASK_TAB [NS] = '{32'hFF00_0000, 32'hFFF0_0000, 32'hFFF0_0000, 32'hFE00_0000};

    logic              clk = 1'b0;
    logic              reset;
    logic              m_valid;
    logic              m_ready;
    logic [3:0]        m_wstrb;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_ready;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [32*NS-1:0]  s_rdata;
    logic              err_irq;
    logic [7:0]        err_count;
    logic [31:0]       err_addr;
    logic              err_timeout;

    picosoc_iomem_mux #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     ({BASE_TAB[3], BASE_TAB[2], BASE_TAB[1], BASE_TAB[0]}),
        .SLAVE_MASK     ({MASK_TAB[3], MASK_TAB[2], MASK_TAB[1], MASK_TAB[0]}),
        .TIMEOUT_CYCLES (T),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_wstrb     (m_wstrb),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .err_irq     (err_irq),
        .err_count   (err_count),
        .err_addr    (err_addr),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- slave models ----------------
    int            busy_cnt  [NS];
    int            wait_cfg  [NS];
    logic [31:0]   rdata_cfg [NS];
    logic [NS-1:0] noise;

    // cycles each slave has seen its strobe high
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++)
            busy_cnt[i] <= s_valid[i] ? busy_cnt[i] + 1 : 0;
    end

    // a slave answers after wait_cfg cycles; unselected slaves toggle ready randomly
    always_comb begin
        s_ready = '0;
        s_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            s_ready[i]          = s_valid[i] ? (busy_cnt[i] >= wait_cfg[i]) : noise[i];
            s_rdata[32*i +: 32] = rdata_cfg[i];
        end
    end

    // ---------------- reference model state ----------------
    int            checks = 0;
    int            errors = 0;
    logic          chk_en = 1'b0;
    logic          exp_ready;
    logic          exp_irq;
    logic [NS-1:0] exp_sv;
    logic [31:0]   exp_saddr;
    logic [31:0]   exp_swdata;
    logic [3:0]    exp_swstrb;
    logic [31:0]   mdl_rdata;
    int            mdl_err_cnt;
    logic [31:0]   mdl_err_addr;
    logic          mdl_err_to;

    int            cyc_idx;
    int            ready_at;
    int            sv_cnt;
    logic [NS-1:0] seen_sv;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int model_sel(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK_TAB[i]) == (BASE_TAB[i] & MASK_TAB[i])) return i;
        return -1;
    endfunction

    task automatic model_error(input logic [31:0] a, input logic to);
        mdl_rdata    = ERR;
        mdl_err_cnt  = (mdl_err_cnt < 255) ? mdl_err_cnt + 1 : 255;
        mdl_err_addr = a;
        mdl_err_to   = to;
    endtask

    task automatic model_reset();
        mdl_rdata    = '0;
        mdl_err_cnt  = 0;
        mdl_err_addr = '0;
        mdl_err_to   = 1'b0;
    endtask

    task automatic exp_idle();
        exp_ready = 1'b0;
        exp_irq   = 1'b0;
        exp_sv    = '0;
    endtask

    // single compare process, sampling away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready",     32'(m_ready),     32'(exp_ready));
            check("s_valid",     32'(s_valid),     32'(exp_sv));
            check("err_irq",     32'(err_irq),     32'(exp_irq));
            check("m_rdata",     m_rdata,          mdl_rdata);
            check("err_count",   32'(err_count),   32'(mdl_err_cnt));
            check("err_addr",    err_addr,         mdl_err_addr);
            check("err_timeout", 32'(err_timeout), 32'(mdl_err_to));
            if (exp_sv != '0) begin
                check("s_addr",  s_addr,           exp_saddr);
                check("s_wdata", s_wdata,          exp_swdata);
                check("s_wstrb", 32'(s_wstrb),     32'(exp_swstrb));
            end
            if (s_valid != '0) sv_cnt++;
            seen_sv = seen_sv | s_valid;
            if (m_ready === 1'b1 && ready_at < 0) ready_at = cyc_idx;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc_idx++;
        noise = NS'($urandom);
    endtask

    // One master transaction; the caller is 1 time unit past a rising edge.
    // Cycle 0 presents the request. abort_at / reset_at (1-based busy cycle,
    // 0 = off) withdraw m_valid or pulse reset during that busy cycle.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int abort_at, input int reset_at);
        int   sel;
        int   busy;
        logic tout;
        sel      = model_sel(addr);
        cyc_idx  = 0;
        sv_cnt   = 0;
        ready_at = -1;
        seen_sv  = '0;
        m_valid  = 1'b1;
        m_addr   = addr;
        m_wstrb  = wstrb;
        m_wdata  = wdata;
        exp_idle();
        if (sel < 0) begin
            next_cycle();
            exp_ready = 1'b1;
            exp_irq   = 1'b1;
            model_error(addr, 1'b0);
        end else begin
            tout = (wait_cfg[sel] >= T);
            busy = tout ? T : wait_cfg[sel] + 1;
            for (int c = 1; c <= busy; c++) begin
                next_cycle();
                exp_sv     = NS'(1) << sel;
                exp_saddr  = addr;
                exp_swdata = wdata;
                exp_swstrb = wstrb;
                if (c == abort_at) begin
                    m_valid = 1'b0;
                    next_cycle();
                    exp_idle();
                    return;
                end
                if (c == reset_at) begin
                    reset = 1'b1;
                    next_cycle();
                    reset   = 1'b0;
                    m_valid = 1'b0;
                    model_reset();
                    exp_idle();
                    return;
                end
            end
            next_cycle();
            exp_sv    = '0;
            exp_ready = 1'b1;
            if (tout) begin
                exp_irq = 1'b1;
                model_error(addr, 1'b1);
            end else begin
                mdl_rdata = rdata_cfg[sel];
            end
        end
        next_cycle();
        m_valid = 1'b0;
        exp_idle();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return {8'h02, r[23:0]};
            1:       return {12'h031, r[19:0]};
            2:       return {12'h032, r[19:0]};
            3:       return {8'h03, 4'h3 + 4'(r[1:0]), r[19:0]};
            4:       return {8'h0F, r[23:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        noise   = '0;
        for (int i = 0; i < NS; i++) begin
            wait_cfg[i]  = 0;
            rdata_cfg[i] = 32'h1111_1111 * (i + 1);
        end
        model_reset();
        exp_idle();
        exp_saddr  = '0;
        exp_swdata = '0;
        exp_swstrb = '0;
        cyc_idx    = 0;
        seen_sv    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;              // reset values: all outputs 0
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // read from slave 1, zero-wait slave
        rdata_cfg[1] = 32'h1234_5678;
        run_txn(32'h0310_0004, 4'b0000, 32'h0, 0, 0);
        check("t1_sv_cycles", 32'(sv_cnt),   32'd1);
        check("t1_ready_at",  32'(ready_at), 32'd2);
        check("t1_rdata",     m_rdata,       32'h1234_5678);

        // write to slave 0 that answers after 3 waits
        wait_cfg[0] = 3;
        run_txn(32'h0200_0010, 4'b0011, 32'hA5A5_5A5A, 0, 0);
        check("t2_sv_cycles", 32'(sv_cnt),    32'd4);
        check("t2_ready_at",  32'(ready_at),  32'd5);
        check("t2_err_count", 32'(err_count), 32'd0);

        // decode error
        run_txn(32'h0F00_0000, 4'b0000, 32'h0, 0, 0);
        check("t3_ready_at",  32'(ready_at),    32'd1);
        check("t3_rdata",     m_rdata,          32'hBADD_ADD5);
        check("t3_err_count", 32'(err_count),   32'd1);
        check("t3_err_addr",  err_addr,         32'h0F00_0000);
        check("t3_err_to",    32'(err_timeout), 32'd0);

        // slave 2 never ready: eight busy cycles, response right after
        wait_cfg[2] = 1000;
        run_txn(32'h0320_0008, 4'b0000, 32'h0, 0, 0);
        check("t4_sv_cycles", 32'(sv_cnt),      32'd8);
        check("t4_ready_at",  32'(ready_at),    32'd9);
        check("t4_rdata",     m_rdata,          32'hBADD_ADD5);
        check("t4_err_to",    32'(err_timeout), 32'd1);
        check("t4_err_addr",  err_addr,         32'h0320_0008);

        // overlapping windows: 0 beats 3; 0x033x_xxxx reaches 3 alone
        wait_cfg[0] = 1;
        run_txn(32'h0200_0100, 4'b1111, 32'hDEAD_BEEF, 0, 0);
        check("t5_only_s0", 32'(seen_sv), 32'b0001);
        run_txn(32'h0330_0000, 4'b0000, 32'h0, 0, 0);
        check("t5_only_s3", 32'(seen_sv), 32'b1000);

        // 300 decode errors saturate the counter
        for (int k = 0; k < 300; k++)
            run_txn(32'h0F00_0000 + 32'(k), 4'b0000, 32'h0, 0, 0);
        check("t6_saturate", 32'(err_count), 32'd255);

        // reset in BUSY: strobe drops, no response, then a clean read
        wait_cfg[1] = 5;
        run_txn(32'h0310_0000, 4'b0000, 32'h0, 0, 2);
        check("t7_no_ready",  32'(ready_at),  32'hFFFF_FFFF);
        check("t7_err_clear", 32'(err_count), 32'd0);
        wait_cfg[1]  = 0;
        rdata_cfg[1] = 32'hCAFE_0001;
        run_txn(32'h0310_0020, 4'b0000, 32'h0, 0, 0);
        check("t7_rdata",     m_rdata,        32'hCAFE_0001);
        check("t7_err_count", 32'(err_count), 32'd0);

        // master withdraws in BUSY: silent abort
        wait_cfg[2] = 6;
        run_txn(32'h0320_0000, 4'b0000, 32'h0, 3, 0);
        check("t8_no_ready",  32'(ready_at),  32'hFFFF_FFFF);
        check("t8_err_count", 32'(err_count), 32'd0);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            int ab;
            for (int i = 0; i < NS; i++) begin
                wait_cfg[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 3));
                rdata_cfg[i] = $urandom;
            end
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_txn(pick_addr(), 4'($urandom), $urandom, ab, 0);
            repeat ($urandom_range(0, 2)) begin
                m_addr = $urandom;
                next_cycle();
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
